// File: rtl/bsg_host_mmio.sv
// ---------------------------------------------------------------------------
// bsg_host_mmio
//
// Host-side memory-mapped I/O endpoint for a multi-core test harness.
// Cores issue commands into three small address windows (bits [addr_width_p-1:12]):
//   0x03000  hprint : print data[7:0] as a hex byte
//   0x03001  cprint : print data[7:0] as a character
//   0x03002  finish : mark the core finished; data[0] = 0 pass, 1 fail
// The core index comes from addr[3 +: clog2(num_core_p)].
// All other addresses are unmapped. They are acknowledged and answered, but
// they have no side effect.
//
// Every accepted command produces exactly one response through a one-entry
// buffer. The response carries the command's hdr and addr, and its data is
// always zero. While the buffer holds a response, no new command is accepted.
//
// Ports
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   mem_cmd_v_i/_addr_i/_data_i/_hdr_i, mem_cmd_yumi_o   command channel
//   mem_resp_v_o, mem_resp_ready_i,
//   mem_resp_addr_o/_hdr_o/_data_o                         response channel
//   program_finish_o   per-core sticky finish flags
//   all_finished_o     AND of program_finish_o, one register stage later
//   pass_o, fail_o     sticky pass / fail indications
//   print_v_o, print_core_o, print_data_o, print_char_o   print event
//
// Optional: define BSG_HOST_MMIO_DISPLAY_EN to have simulation print each
// accepted print or finish command, plus a final "All cores finished!".
// ---------------------------------------------------------------------------
module bsg_host_mmio #(
    parameter int num_core_p   = 1,
    parameter int addr_width_p = 40,
    parameter int data_width_p = 64,
    parameter int hdr_width_p  = 16,
    localparam int core_w_lp   = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic                    mem_cmd_v_i,
    input  logic [addr_width_p-1:0] mem_cmd_addr_i,
    input  logic [data_width_p-1:0] mem_cmd_data_i,
    input  logic [hdr_width_p-1:0]  mem_cmd_hdr_i,
    output logic                    mem_cmd_yumi_o,

    output logic                    mem_resp_v_o,
    input  logic                    mem_resp_ready_i,
    output logic [addr_width_p-1:0] mem_resp_addr_o,
    output logic [hdr_width_p-1:0]  mem_resp_hdr_o,
    output logic [data_width_p-1:0] mem_resp_data_o,

    output logic [num_core_p-1:0]   program_finish_o,
    output logic                    all_finished_o,
    output logic                    pass_o,
    output logic                    fail_o,

    output logic                    print_v_o,
    output logic [core_w_lp-1:0]    print_core_o,
    output logic [7:0]              print_data_o,
    output logic                    print_char_o
);

    localparam int region_w_lp = addr_width_p - 12;
    localparam logic [region_w_lp-1:0] hprint_region_lp = region_w_lp'(32'h03000);
    localparam logic [region_w_lp-1:0] cprint_region_lp = region_w_lp'(32'h03001);
    localparam logic [region_w_lp-1:0] finish_region_lp = region_w_lp'(32'h03002);

    // ---------------- command decode ----------------
    logic [region_w_lp-1:0] region;
    logic [core_w_lp-1:0]   core_idx;
    logic                   core_valid;
    logic                   cmd_accept;
    logic                   hprint_v, cprint_v, finish_v;
    logic [num_core_p-1:0]  finish_hit;

    logic                    full_q, full_d;
    logic [addr_width_p-1:0] resp_addr_q, resp_addr_d;
    logic [hdr_width_p-1:0]  resp_hdr_q, resp_hdr_d;
    logic [num_core_p-1:0]   finish_q, finish_d;
    logic                    all_finished_q, all_finished_d;
    logic                    pass_q, pass_d;
    logic                    fail_q, fail_d;

    assign region = mem_cmd_addr_i[addr_width_p-1:12];

    // With a single core there are no index bits, so the index is always 0.
    generate
        if (num_core_p > 1) begin : g_multi_core
            assign core_idx = mem_cmd_addr_i[3 +: core_w_lp];
        end else begin : g_single_core
            assign core_idx = '0;
        end
    endgenerate

    // When num_core_p is not a power of two, an index past the last core
    // selects no core.
    assign core_valid = (int'(core_idx) < num_core_p);

    // Reset is included here so that the handshake stays quiet while reset
    // is held, even if the upstream side is already presenting a command.
    assign mem_cmd_yumi_o = mem_cmd_v_i & ~full_q & reset_n_i;
    assign cmd_accept     = mem_cmd_v_i & mem_cmd_yumi_o;

    assign hprint_v = cmd_accept & (region == hprint_region_lp);
    assign cprint_v = cmd_accept & (region == cprint_region_lp);
    assign finish_v = cmd_accept & (region == finish_region_lp);

    generate
        for (genvar gi = 0; gi < num_core_p; gi++) begin : g_finish_hit
            assign finish_hit[gi] = finish_v & core_valid
                                  & (core_idx == core_w_lp'(gi));
        end
    endgenerate

    // ---------------- next state ----------------
    always_comb begin
        full_d         = full_q;
        resp_addr_d    = resp_addr_q;
        resp_hdr_d     = resp_hdr_q;
        finish_d       = finish_q | finish_hit;
        all_finished_d = &finish_q;
        pass_d         = pass_q;
        fail_d         = fail_q;

        // Accept only happens while empty, and drain only happens while full,
        // so the two branches can never fire together.
        if (cmd_accept) begin
            full_d      = 1'b1;
            resp_addr_d = mem_cmd_addr_i;
            resp_hdr_d  = mem_cmd_hdr_i;
        end else if (mem_resp_v_o) begin
            full_d = 1'b0;
        end

        if (finish_v && core_valid) begin
            if (mem_cmd_data_i[0]) fail_d = 1'b1;
            else                   pass_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            full_q         <= 1'b0;
            resp_addr_q    <= '0;
            resp_hdr_q     <= '0;
            finish_q       <= '0;
            all_finished_q <= 1'b0;
            pass_q         <= 1'b0;
            fail_q         <= 1'b0;
        end else begin
            full_q         <= full_d;
            resp_addr_q    <= resp_addr_d;
            resp_hdr_q     <= resp_hdr_d;
            finish_q       <= finish_d;
            all_finished_q <= all_finished_d;
            pass_q         <= pass_d;
            fail_q         <= fail_d;
        end
    end

    // ---------------- outputs ----------------
    assign mem_resp_v_o    = full_q & mem_resp_ready_i;
    assign mem_resp_addr_o = resp_addr_q;
    assign mem_resp_hdr_o  = resp_hdr_q;
    assign mem_resp_data_o = '0;

    assign program_finish_o = finish_q;
    assign all_finished_o   = all_finished_q;
    assign pass_o           = pass_q;
    assign fail_o           = fail_q;

    assign print_v_o    = (hprint_v | cprint_v) & core_valid;
    assign print_core_o = core_idx;
    assign print_data_o = mem_cmd_data_i[7:0];
    assign print_char_o = cprint_v;

    // Only the decoded fields are used. This reduction collects the remaining
    // bits so they do not show up as dangling inputs.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{mem_cmd_addr_i, mem_cmd_data_i};

`ifdef BSG_HOST_MMIO_DISPLAY_EN
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            if (hprint_v && core_valid)
                $display("[CORE%0d PRT] %x", core_idx, mem_cmd_data_i[7:0]);
            if (cprint_v && core_valid)
                $display("[CORE%0d PRT] %c", core_idx, mem_cmd_data_i[7:0]);
            if (finish_v && core_valid)
                $display("[CORE%0d FSH] %s", core_idx,
                         mem_cmd_data_i[0] ? "FAIL" : "PASS");
            // The finish flags are sticky, so this edge occurs only once per reset.
            if (all_finished_d && !all_finished_q)
                $display("All cores finished!");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_host_mmio.sv
// ---------------------------------------------------------------------------
// Directed testbench for bsg_host_mmio (num_core_p = 2).
// Inputs are driven on the falling edge. Outputs are sampled 1 time unit
// later, which keeps all sampling well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_bsg_host_mmio;

    localparam int NC = 2;
    localparam int AW = 40;
    localparam int DW = 64;
    localparam int HW = 16;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          mem_cmd_v_i;
    logic [AW-1:0] mem_cmd_addr_i;
    logic [DW-1:0] mem_cmd_data_i;
    logic [HW-1:0] mem_cmd_hdr_i;
    logic          mem_cmd_yumi_o;
    logic          mem_resp_v_o;
    logic          mem_resp_ready_i;
    logic [AW-1:0] mem_resp_addr_o;
    logic [HW-1:0] mem_resp_hdr_o;
    logic [DW-1:0] mem_resp_data_o;
    logic [NC-1:0] program_finish_o;
    logic          all_finished_o;
    logic          pass_o;
    logic          fail_o;
    logic          print_v_o;
    logic [0:0]    print_core_o;
    logic [7:0]    print_data_o;
    logic          print_char_o;

    int n_cmp = 0;
    int n_bad = 0;

    bsg_host_mmio #(
        .num_core_p  (NC),
        .addr_width_p(AW),
        .data_width_p(DW),
        .hdr_width_p (HW)
    ) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .mem_cmd_v_i     (mem_cmd_v_i),
        .mem_cmd_addr_i  (mem_cmd_addr_i),
        .mem_cmd_data_i  (mem_cmd_data_i),
        .mem_cmd_hdr_i   (mem_cmd_hdr_i),
        .mem_cmd_yumi_o  (mem_cmd_yumi_o),
        .mem_resp_v_o    (mem_resp_v_o),
        .mem_resp_ready_i(mem_resp_ready_i),
        .mem_resp_addr_o (mem_resp_addr_o),
        .mem_resp_hdr_o  (mem_resp_hdr_o),
        .mem_resp_data_o (mem_resp_data_o),
        .program_finish_o(program_finish_o),
        .all_finished_o  (all_finished_o),
        .pass_o          (pass_o),
        .fail_o          (fail_o),
        .print_v_o       (print_v_o),
        .print_core_o    (print_core_o),
        .print_data_o    (print_data_o),
        .print_char_o    (print_char_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one command on the next falling edge, then wait for the
    // outputs to settle.
    task automatic drive(input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [HW-1:0] h,
                         input logic rdy);
        @(negedge clk_i);
        mem_cmd_v_i      = v;
        mem_cmd_addr_i   = a;
        mem_cmd_data_i   = d;
        mem_cmd_hdr_i    = h;
        mem_resp_ready_i = rdy;
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, '0, '0, '0, rdy);
    endtask

    initial begin
        reset_n_i        = 1'b0;
        mem_cmd_v_i      = 1'b1;
        mem_cmd_addr_i   = 40'h0300_1000;
        mem_cmd_data_i   = 64'h41;
        mem_cmd_hdr_i    = '0;
        mem_resp_ready_i = 1'b1;

        // Reset state, with a command already being presented.
        repeat (2) @(negedge clk_i);
        #1;
        check_eq("rst_yumi",   64'(mem_cmd_yumi_o),   0);
        check_eq("rst_respv",  64'(mem_resp_v_o),     0);
        check_eq("rst_printv", 64'(print_v_o),        0);
        check_eq("rst_finish", 64'(program_finish_o), 0);
        check_eq("rst_allfin", 64'(all_finished_o),   0);
        check_eq("rst_pass",   64'(pass_o),           0);
        check_eq("rst_fail",   64'(fail_o),           0);
        $display("txn reset: checked");

        @(negedge clk_i);
        reset_n_i   = 1'b1;
        mem_cmd_v_i = 1'b0;

        // cprint 'A' to core 0 with ready high.
        drive(1'b1, 40'h0300_1000, 64'h41, 16'h1234, 1'b1);
        check_eq("c1_yumi",  64'(mem_cmd_yumi_o), 1);
        check_eq("c1_printv", 64'(print_v_o),     1);
        check_eq("c1_char",  64'(print_char_o),   1);
        check_eq("c1_data",  64'(print_data_o),   64'h41);
        check_eq("c1_core",  64'(print_core_o),   0);
        check_eq("c1_respv0", 64'(mem_resp_v_o),  0);
        idle(1'b1);
        check_eq("c1_respv", 64'(mem_resp_v_o),    1);
        check_eq("c1_rdata", mem_resp_data_o,      0);
        check_eq("c1_raddr", 64'(mem_resp_addr_o), 64'h0300_1000);
        check_eq("c1_rhdr",  64'(mem_resp_hdr_o),  64'h1234);
        idle(1'b1);
        check_eq("c1_drained", 64'(mem_resp_v_o), 0);
        $display("txn cprint: done");

        // Back-to-back commands with ready held low.
        drive(1'b1, 40'h0300_0008, 64'h5a, 16'h0001, 1'b0);
        check_eq("b2b_yumi1",  64'(mem_cmd_yumi_o), 1);
        check_eq("b2b_printv", 64'(print_v_o),      1);
        check_eq("b2b_char",   64'(print_char_o),   0);
        check_eq("b2b_core",   64'(print_core_o),   1);
        drive(1'b1, 40'h0300_0000, 64'h77, 16'h0002, 1'b0);
        check_eq("b2b_stall_yumi",  64'(mem_cmd_yumi_o), 0);
        check_eq("b2b_stall_printv", 64'(print_v_o),     0);
        check_eq("b2b_stall_respv", 64'(mem_resp_v_o),   0);
        drive(1'b1, 40'h0300_0000, 64'h77, 16'h0002, 1'b0);
        check_eq("b2b_stall2_yumi", 64'(mem_cmd_yumi_o), 0);
        drive(1'b1, 40'h0300_0000, 64'h77, 16'h0002, 1'b1);
        check_eq("b2b_drain_respv", 64'(mem_resp_v_o),   1);
        check_eq("b2b_drain_hdr",   64'(mem_resp_hdr_o), 1);
        check_eq("b2b_drain_yumi",  64'(mem_cmd_yumi_o), 0);
        drive(1'b1, 40'h0300_0000, 64'h77, 16'h0002, 1'b1);
        check_eq("b2b_yumi2",  64'(mem_cmd_yumi_o), 1);
        check_eq("b2b_pdata2", 64'(print_data_o),   64'h77);
        idle(1'b1);
        check_eq("b2b_resp2_v",   64'(mem_resp_v_o),   1);
        check_eq("b2b_resp2_hdr", 64'(mem_resp_hdr_o), 2);
        $display("txn back-to-back: done");

        // Finish core 0 and then core 1, both passing.
        drive(1'b1, 40'h0300_2000, 64'h0, 16'h0003, 1'b1);
        check_eq("f0_yumi",   64'(mem_cmd_yumi_o), 1);
        check_eq("f0_printv", 64'(print_v_o),      0);
        idle(1'b1);
        check_eq("f0_finish", 64'(program_finish_o), 64'b01);
        check_eq("f0_allfin", 64'(all_finished_o),    0);
        check_eq("f0_pass",   64'(pass_o),            1);
        check_eq("f0_fail",   64'(fail_o),            0);
        check_eq("f0_respv",  64'(mem_resp_v_o),      1);
        drive(1'b1, 40'h0300_2008, 64'h0, 16'h0004, 1'b1);
        check_eq("f1_yumi", 64'(mem_cmd_yumi_o), 1);
        idle(1'b1);
        check_eq("f1_finish", 64'(program_finish_o), 64'b11);
        check_eq("f1_allfin", 64'(all_finished_o),   0);
        idle(1'b1);
        check_eq("f1_allfin_late", 64'(all_finished_o), 1);
        check_eq("f1_pass", 64'(pass_o), 1);
        check_eq("f1_fail", 64'(fail_o), 0);
        $display("txn finish pass: done");

        // A finish with data 1 sets fail, and pass stays set too.
        drive(1'b1, 40'h0300_2000, 64'h1, 16'h0005, 1'b1);
        idle(1'b1);
        check_eq("ff_fail", 64'(fail_o), 1);
        check_eq("ff_pass", 64'(pass_o), 1);
        idle(1'b1);
        $display("txn finish fail: done");

        // An unmapped address is acknowledged and answered with no side effect.
        drive(1'b1, 40'h0400_0000, 64'h1, 16'h0006, 1'b1);
        check_eq("um_yumi",   64'(mem_cmd_yumi_o), 1);
        check_eq("um_printv", 64'(print_v_o),      0);
        idle(1'b1);
        check_eq("um_respv",   64'(mem_resp_v_o),     1);
        check_eq("um_raddr",   64'(mem_resp_addr_o),  64'h0400_0000);
        check_eq("um_finish",  64'(program_finish_o), 64'b11);
        check_eq("um_pass",    64'(pass_o),           1);
        check_eq("um_fail",    64'(fail_o),           1);
        idle(1'b1);
        $display("txn unmapped: done");

        // Reset while a response is still buffered.
        drive(1'b1, 40'h0300_1000, 64'h42, 16'h0007, 1'b0);
        idle(1'b0);
        check_eq("mr_held", 64'(mem_resp_v_o), 0);
        mem_resp_ready_i = 1'b1;
        #1;
        check_eq("mr_ready_respv", 64'(mem_resp_v_o), 1);
        reset_n_i = 1'b0;
        #1;
        check_eq("mr_rst_respv",  64'(mem_resp_v_o),     0);
        check_eq("mr_rst_finish", 64'(program_finish_o), 0);
        check_eq("mr_rst_allfin", 64'(all_finished_o),   0);
        check_eq("mr_rst_pass",   64'(pass_o),           0);
        check_eq("mr_rst_fail",   64'(fail_o),           0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        idle(1'b1);
        check_eq("mr_post_respv", 64'(mem_resp_v_o), 0);
        idle(1'b1);
        check_eq("mr_post2_respv", 64'(mem_resp_v_o), 0);
        check_eq("mr_post_yumi",   64'(mem_cmd_yumi_o), 0);
        $display("txn mid-reset: done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
